// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: a one-byte holding register feeds the shift register,
// and frames go out LSB-first, timed by a 16x baud tick.
module uart_tx_serializer #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [12:0] BAUD_VAL,
  input  logic [7:0]  DATA_IN,
  input  logic        WEN,
  output logic        TXRDY,
  output logic        TX,
  output logic        BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t      state_reg, state_next;
  logic [12:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]  tick_cnt_reg, tick_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  hold_reg, hold_next;
  logic [7:0]  shift_reg, shift_next;
  logic        hold_full_reg, hold_full_next;
  logic        parity_reg, parity_next;
  logic        tick, bit_end, accept, load;

  assign tick    = (baud_cnt_reg == 13'd0);
  assign bit_end = tick && (tick_cnt_reg == 4'd15);
  assign accept  = !WEN && !hold_full_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= 13'd0;
      tick_cnt_reg  <= 4'd0;
      bit_idx_reg   <= 3'd0;
      hold_reg      <= 8'd0;
      shift_reg     <= 8'd0;
      hold_full_reg <= 1'b0;
      parity_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      hold_reg      <= hold_next;
      shift_reg     <= shift_next;
      hold_full_reg <= hold_full_next;
      parity_reg    <= parity_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    parity_next    = parity_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    load           = 1'b0;
    baud_cnt_next  = tick ? BAUD_VAL : baud_cnt_reg - 13'd1;
    tick_cnt_next  = tick ? tick_cnt_reg + 4'd1 : tick_cnt_reg;

    unique case (state_reg)
      IDLE: load = hold_full_reg;
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          bit_idx_next = 3'd0;
        end
      end
      STOP: begin
        // Bit index doubles as the stop-bit counter; a full holding register
        // chains straight into the next start bit with no idle clock.
        if (bit_end) begin
          if (bit_idx_reg == LAST_STOP) begin
            if (hold_full_reg) load = 1'b1;
            else state_next = IDLE;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame load restarts the bit timing so the first bit is exact from this edge.
    if (load) begin
      state_next     = START;
      shift_next     = hold_reg;
      parity_next    = (^hold_reg) ^ PARITY_ODD;
      hold_full_next = 1'b0;
      baud_cnt_next  = BAUD_VAL;
      tick_cnt_next  = 4'd0;
      bit_idx_next   = 3'd0;
    end

    if (accept) begin
      hold_next      = DATA_IN;
      hold_full_next = 1'b1;
    end
  end

  always_comb begin
    TX = 1'b1;
    unique case (state_reg)
      START:   TX = 1'b0;
      DATA:    TX = shift_reg[0];
      PARITY:  TX = parity_reg;
      default: TX = 1'b1;
    endcase
  end

  assign TXRDY = !hold_full_reg;
  assign BUSY  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations, a waveform-level reference model
// checked every clock, a table of single frames, and hand-written corner sequences.
module tb_uart_tx_serializer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [12:0] BAUD_VAL = 13'd0;
  logic [7:0]  DATA_IN = 8'd0;
  logic [3:0]  wen = 4'hF;
  logic [3:0]  tx, txrdy, busy;

  int chk = 0;
  int err = 0;
  int sel = 0;

  always #5 CLK = ~CLK;

  // cfg 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_dut
    uart_tx_serializer #(
      .PARITY_EN (gi == 1 || gi == 2),
      .PARITY_ODD(gi == 2),
      .STOP_BITS (gi == 3 ? 2 : 1)
    ) u_dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .BAUD_VAL(BAUD_VAL),
      .DATA_IN (DATA_IN),
      .WEN     (wen[gi]),
      .TXRDY   (txrdy[gi]),
      .TX      (tx[gi]),
      .BUSY    (busy[gi])
    );
  end

  function automatic bit cfg_pen(input int c);
    return (c == 1) || (c == 2);
  endfunction
  function automatic bit cfg_podd(input int c);
    return c == 2;
  endfunction
  function automatic int cfg_nstop(input int c);
    return (c == 3) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held for one bit time.
  bit         m_act = 1'b0;
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'd0;
  logic       m_bits [0:11];
  int         m_nb = 0, m_bt = 16, m_len = 0, m_el = 0;

  task automatic m_load(input logic [7:0] d);
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1 + i] = d[i];
    m_nb = 9;
    if (cfg_pen(sel)) begin
      m_bits[9] = (^d) ^ cfg_podd(sel);
      m_nb = 10;
    end
    for (int i = 0; i < cfg_nstop(sel); i++) begin
      m_bits[m_nb] = 1'b1;
      m_nb++;
    end
    m_bt  = 16 * (int'(BAUD_VAL) + 1);
    m_len = m_nb * m_bt;
    m_el  = 0;
    m_act = 1'b1;
  endtask

  task automatic step();
    bit   ended, acc;
    logic exp_tx;
    @(posedge CLK);
    if (RESET) begin
      m_act  = 1'b0;
      m_full = 1'b0;
    end else begin
      ended = 1'b0;
      if (m_act) begin
        m_el++;
        if (m_el == m_len) ended = 1'b1;
      end
      acc = !wen[sel] && !m_full;
      if (m_full && (!m_act || ended)) begin
        m_load(m_hold);
        m_full = 1'b0;
      end else if (ended) begin
        m_act = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_hold = DATA_IN;
      end
    end
    #1;
    exp_tx = m_act ? m_bits[m_el / m_bt] : 1'b1;
    check("model", 32'({tx[sel], txrdy[sel], busy[sel]}), 32'({exp_tx, !m_full, m_act}));
  endtask

  task automatic wr(input logic [7:0] d);
    DATA_IN  = d;
    wen[sel] = 1'b0;
    step();
    wen[sel] = 1'b1;
  endtask

  typedef struct {
    int         cfg;
    int         baud;
    logic [7:0] data;
    int         exp_len;
    logic       exp_par;
  } vec_t;
  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    int   k, nbusy, slot, bt;
    logic exp;
    bt       = 16 * (v.baud + 1);
    sel      = v.cfg;
    BAUD_VAL = 13'(v.baud);
    wr(v.data);
    check("txrdy_after_write", 32'(txrdy[sel]), 32'd0);
    step();
    check("load_txrdy_tx", 32'({txrdy[sel], tx[sel]}), 32'b10);
    k = 0;
    nbusy = 0;
    while (busy[sel] && k < v.exp_len + 16) begin
      if (k % bt == bt / 2) begin
        slot = k / bt;
        if (slot == 0) exp = 1'b0;
        else if (slot <= 8) exp = v.data[slot - 1];
        else if (cfg_pen(v.cfg) && slot == 9) exp = v.exp_par;
        else exp = 1'b1;
        check($sformatf("cfg%0d_%02h_slot%0d", v.cfg, v.data, slot), 32'(tx[sel]), 32'(exp));
      end
      nbusy++;
      k++;
      step();
    end
    check($sformatf("cfg%0d_%02h_len", v.cfg, v.data), 32'(nbusy), 32'(v.exp_len));
  endtask

  // Follows two chained default frames at BAUD_VAL=0; j counts samples since the first load.
  task automatic follow(input int j0, input logic [7:0] second, input string tag);
    int j;
    j = j0;
    while (busy[sel] && j < 400) begin
      if (j == 159) check({tag, "_stop1"}, 32'(tx[sel]), 32'd1);
      if (j == 160) check({tag, "_start2"}, 32'(tx[sel]), 32'd0);
      for (int i = 0; i < 8; i++)
        if (j == 160 + 16 * (i + 1) + 8)
          check($sformatf("%s_d%0d", tag, i), 32'(tx[sel]), 32'(second[i]));
      j++;
      step();
    end
    check({tag, "_len"}, 32'(j), 32'd320);
  endtask

  initial begin
    vecs[0] = '{cfg: 0, baud: 0,   data: 8'hA5, exp_len: 160,   exp_par: 1'b0};
    vecs[1] = '{cfg: 1, baud: 0,   data: 8'h07, exp_len: 176,   exp_par: 1'b1};
    vecs[2] = '{cfg: 2, baud: 0,   data: 8'h07, exp_len: 176,   exp_par: 1'b0};
    vecs[3] = '{cfg: 0, baud: 1,   data: 8'h3C, exp_len: 320,   exp_par: 1'b0};
    vecs[4] = '{cfg: 3, baud: 325, data: 8'h81, exp_len: 57376, exp_par: 1'b0};

    for (int n = 0; n < 3; n++) step();
    check("reset_state", 32'({tx, txrdy, busy}), 32'({4'hF, 4'hF, 4'h0}));
    RESET = 1'b0;
    for (int n = 0; n < 4; n++) step();

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    sel = 0;
    BAUD_VAL = 13'd0;
    wr(8'h55);
    step();
    wr(8'h0F);
    follow(1, 8'h0F, "b2b");

    wr(8'h44);
    step();
    wr(8'h11);
    wr(8'h22);
    check("ignored_write_txrdy", 32'(txrdy[sel]), 32'd0);
    follow(2, 8'h11, "ignored");

    // Reset in the middle of data bit 3 with a second byte waiting in the holding register.
    wr(8'hC3);
    step();
    wr(8'h99);
    for (int n = 0; n < 69; n++) step();
    RESET = 1'b1;
    #1;
    m_act  = 1'b0;
    m_full = 1'b0;
    check("reset_async", 32'({tx[sel], txrdy[sel], busy[sel]}), 32'b110);
    step();
    step();
    RESET = 1'b0;
    for (int n = 0; n < 40; n++) step();
    run_vec(vecs[3]);

    for (int c = 0; c < 4; c++) begin
      sel = c;
      BAUD_VAL = 13'($urandom_range(0, 2));
      for (int n = 0; n < 1500; n++) begin
        DATA_IN  = 8'($urandom);
        wen[sel] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        step();
      end
      wen[sel] = 1'b1;
      for (int n = 0; n < 2000 && (busy[sel] || !txrdy[sel]); n++) step();
      check($sformatf("drain_cfg%0d", c), 32'({busy[sel], txrdy[sel]}), 32'b01);
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
